snes_multitap_port: RTL and testbench

Parametrised SNES controller-port serializer, the successor to the single-pad/mouse port block. It presents up to four joypads through a multitap, one joypad, or one mouse with speed cycling on a single controller port. It sits between the HPS joystick/mouse inputs and the CPU's serial joypad pins, one instance per port, all in the CLK domain.

---
 rtl/snes_multitap_port.sv | 148 ++++++++++++++
 tb/tb_snes_multitap_port.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_multitap_port.sv
// SNES controller-port serializer: one joypad, a four-pad multitap, or a mouse
// with speed cycling, all driven onto the CPU's serial joypad lines.
module snes_multitap_port #(
    parameter int NUM_PADS = 4,
    parameter int PAD_BITS = 16
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic [1:0]              MODE,
    input  logic                    PORT_LATCH,
    input  logic                    PORT_CLK,
    input  logic                    PORT_SEL,
    output logic [1:0]              PORT_DO,
    input  logic [12*NUM_PADS-1:0]  JOYSTICK,
    input  logic [24:0]             MOUSE
);
    localparam int MSB = PAD_BITS - 1;

    logic prev_clk, prev_latch, prev_strobe;
    logic clk_rise, latch_fall, strobe;
    logic is_tap, is_mouse;

    assign clk_rise   = PORT_CLK & ~prev_clk;
    assign latch_fall = prev_latch & ~PORT_LATCH;
    assign strobe     = MOUSE[24] ^ prev_strobe;
    assign is_tap     = (MODE == 2'd2);
    assign is_mouse   = (MODE == 2'd1);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            prev_clk    <= 1'b1;
            prev_latch  <= 1'b0;
            prev_strobe <= MOUSE[24];
        end else begin
            prev_clk    <= PORT_CLK;
            prev_latch  <= PORT_LATCH;
            prev_strobe <= MOUSE[24];
        end
    end

    logic [3:0][PAD_BITS-1:0] sr;

    for (genvar n = 0; n < 4; n++) begin : g_pad
        if (n < NUM_PADS) begin : g_live
            logic [11:0]         j;
            logic [PAD_BITS-1:0] frame;
            logic [PAD_BITS-1:0] q;
            logic                sh;

            assign j = JOYSTICK[12*n +: 12];
            // Wire order B,Y,Sel,Start,Up,Down,Left,Right,A,X,L,R then zero ID bits
            always_comb begin
                frame = '0;
                frame[MSB -: 12] = {j[5], j[7], j[10], j[11], j[3], j[2],
                                    j[1], j[0], j[4], j[6], j[8], j[9]};
            end
            assign sh = is_tap ? (PORT_SEL == 1'(n < 2)) : 1'(n == 0);

            always_ff @(posedge CLK) begin
                if (!RESET_N)
                    q <= '1;
                else if (PORT_LATCH)
                    q <= ~frame;
                else if (clk_rise && sh)
                    q <= {q[MSB-1:0], 1'b0};
            end
            assign sr[n] = q;
        end else begin : g_idle
            assign sr[n] = '1;
        end
    end

    logic signed [10:0] ax, ay;
    logic signed [11:0] dx, dy, sum_x, sum_y;
    logic [10:0]        nax, nay;
    logic [6:0]         mag_x, mag_y;
    logic               sdx, sdy;
    logic [1:0]         speed;
    logic [31:0]        ms;
    logic               unused;

    assign unused = ^{MOUSE[3:2], MOUSE[7:6]};

    function automatic logic signed [11:0] scale(input logic signed [11:0] d,
                                                 input logic [1:0] spd);
        case (spd)
            2'd1:    return d + (d >>> 1);
            2'd2:    return d <<< 1;
            default: return d;
        endcase
    endfunction

    function automatic logic signed [10:0] clamp(input logic signed [11:0] v);
        if (v > 12'sd127)  return 11'sd127;
        if (v < -12'sd127) return -11'sd127;
        return v[10:0];
    endfunction

    assign dx = {{3{MOUSE[4]}}, MOUSE[4], MOUSE[15:8]};
    assign dy = {{3{MOUSE[5]}}, MOUSE[5], MOUSE[23:16]};
    // A strobe landing on the latch fall accumulates into the freshly cleared value
    assign sum_x = (latch_fall ? 12'sd0 : {ax[10], ax}) + scale(dx, speed);
    assign sum_y = (latch_fall ? 12'sd0 : {ay[10], ay}) + scale(dy, speed);
    assign nax   = -ax;
    assign nay   = -ay;
    assign mag_x = ax[10] ? nax[6:0] : ax[6:0];
    assign mag_y = ay[10] ? nay[6:0] : ay[6:0];

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ax    <= '0;
            ay    <= '0;
            sdx   <= 1'b0;
            sdy   <= 1'b0;
            speed <= 2'd0;
            ms    <= '1;
        end else begin
            if (strobe) begin
                ax  <= clamp(sum_x);
                ay  <= clamp(sum_y);
                sdx <= sum_x[11];
                sdy <= ~sum_y[11];
            end else if (latch_fall) begin
                ax <= '0;
                ay <= '0;
            end
            if (latch_fall)
                ms <= ~{8'h00, MOUSE[1], MOUSE[0], speed, 4'b0001,
                        sdy, mag_y, sdx, mag_x};
            else if (clk_rise && !PORT_LATCH)
                ms <= {ms[30:0], 1'b0};
            if (clk_rise && PORT_LATCH)
                speed <= (speed == 2'd2) ? 2'd0 : speed + 2'd1;
        end
    end

    always_comb begin
        PORT_DO = {1'b1, sr[0][MSB]};
        if (is_mouse)
            PORT_DO = {1'b1, ms[31]};
        else if (is_tap) begin
            PORT_DO = PORT_SEL ? {sr[1][MSB], sr[0][MSB]} : {sr[3][MSB], sr[2][MSB]};
            // D1 low while latched tells the game a multitap is present
            if (PORT_LATCH)
                PORT_DO[1] = 1'b0;
        end
    end
endmodule

// File: tb/tb_snes_multitap_port.sv
// Directed bench for snes_multitap_port: a 4-pad and a 2-pad instance share stimulus.
module tb_snes_multitap_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        latch = 1'b0, pclk = 1'b0, sel = 1'b1;
    logic [47:0] joy = '0;
    logic [24:0] mouse = '0;
    logic [1:0]  do4, do2;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    snes_multitap_port #(.NUM_PADS(4), .PAD_BITS(16)) dut4 (
        .CLK(clk), .RESET_N(rst_n), .MODE(mode), .PORT_LATCH(latch),
        .PORT_CLK(pclk), .PORT_SEL(sel), .PORT_DO(do4), .JOYSTICK(joy), .MOUSE(mouse));

    snes_multitap_port #(.NUM_PADS(2), .PAD_BITS(16)) dut2 (
        .CLK(clk), .RESET_N(rst_n), .MODE(mode), .PORT_LATCH(latch),
        .PORT_CLK(pclk), .PORT_SEL(sel), .PORT_DO(do2), .JOYSTICK(joy[23:0]), .MOUSE(mouse));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        pclk = 1'b1; step(2);
        pclk = 1'b0; step(2);
    endtask

    task automatic do_latch();
        latch = 1'b1; step(2);
        latch = 1'b0; step(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; step(1);
    endtask

    task automatic strobe(input logic [7:0] dxv);
        mouse[15:8] = dxv;
        mouse[4]    = 1'b0;
        mouse[23:16] = 8'd0;
        mouse[5]    = 1'b0;
        mouse[24]   = ~mouse[24];
        step(2);
    endtask

    // Line level of bit i of a pad frame: inverted button, ones for ID bits, zero after
    function automatic logic pad_line(input logic [11:0] j, input int i);
        int order [12] = '{5, 7, 10, 11, 3, 2, 1, 0, 4, 6, 8, 9};
        if (i < 12) return ~j[order[i]];
        if (i < 16) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; step(3);
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m); #1;
            n_chk++;
            if (do4 !== 2'b11) $display("FAIL reset_do4 mode=%0d got=%b want=11", m, do4);
            else n_pass++;
            n_chk++;
            if (do2 !== 2'b11) $display("FAIL reset_do2 mode=%0d got=%b want=11", m, do2);
            else n_pass++;
        end
        mode = 2'd0;
        rst_n = 1'b1; step(2);
    endtask

    task automatic test_single();
        logic exp [17] = '{0,1,1,0,1,1,1,1,1,1,1,1,1,1,1,1,0};
        mode = 2'd0;
        joy = '0;
        joy[11:0] = 12'h820;
        latch = 1'b1; step(2);
        pclk = 1'b1; step(2);
        pclk = 1'b0; step(2);
        latch = 1'b0; step(2);
        for (int i = 0; i < 17; i++) begin
            n_chk++;
            if (do4 !== {1'b1, exp[i]})
                $display("FAIL single_bit%0d got=%b want=%b", i, do4, {1'b1, exp[i]});
            else n_pass++;
            if (i < 16) pulse();
        end
    endtask

    task automatic test_multitap();
        logic [1:0] want;
        mode = 2'd2;
        joy = '0;
        joy[3]      = 1'b1;  // pad0 Up
        joy[12+10]  = 1'b1;  // pad1 Select
        joy[24+4]   = 1'b1;  // pad2 A
        joy[36+9]   = 1'b1;  // pad3 R
        sel = 1'b0;
        latch = 1'b1; step(2);
        n_chk++;
        if (do4 !== 2'b01) $display("FAIL tap_latch_sig got=%b want=01", do4);
        else n_pass++;
        latch = 1'b0; step(2);
        for (int i = 0; i < 17; i++) begin
            want = {(i == 11) ? 1'b0 : (i < 16), (i == 8) ? 1'b0 : (i < 16)};
            n_chk++;
            if (do4 !== want) $display("FAIL tap_sel0_bit%0d got=%b want=%b", i, do4, want);
            else n_pass++;
            n_chk++;
            if (do2 !== 2'b11) $display("FAIL tap2_idle_bit%0d got=%b want=11", i, do2);
            else n_pass++;
            if (i < 16) pulse();
        end
        sel = 1'b1; step(1);
        for (int i = 0; i < 17; i++) begin
            want = {pad_line(joy[23:12], i), pad_line(joy[11:0], i)};
            n_chk++;
            if (do4 !== want) $display("FAIL tap_sel1_bit%0d got=%b want=%b", i, do4, want);
            else n_pass++;
            if (i < 16) pulse();
        end
    endtask

    task automatic test_mouse();
        logic [31:0] f1, f2;
        f1 = {8'h00, 1'b0, 1'b1, 2'b00, 4'b0001, 1'b1, 7'd0, 1'b0, 7'd127};
        f2 = {8'h00, 1'b0, 1'b1, 2'b00, 4'b0001, 1'b1, 7'd0, 1'b0, 7'd0};
        mode = 2'd1;
        sel = 1'b1;
        mouse = '0;
        mouse[0] = 1'b1;
        do_reset();
        strobe(8'd100);
        strobe(8'd100);
        strobe(8'd100);
        do_latch();
        for (int i = 0; i < 33; i++) begin
            n_chk++;
            if (do4 !== {1'b1, (i < 32) ? ~f1[31-i] : 1'b0})
                $display("FAIL mouse_f1_bit%0d got=%b want=%b", i, do4,
                         {1'b1, (i < 32) ? ~f1[31-i] : 1'b0});
            else n_pass++;
            if (i < 32) pulse();
        end
        do_latch();
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (do4 !== {1'b1, ~f2[31-i]})
                $display("FAIL mouse_f2_bit%0d got=%b want=%b", i, do4, {1'b1, ~f2[31-i]});
            else n_pass++;
            pulse();
        end
    endtask

    task automatic test_speed();
        logic [1:0] exp_spd [3] = '{2'd1, 2'd2, 2'd0};
        mode = 2'd1;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            latch = 1'b1; step(2);
            pulse();
            latch = 1'b0; step(2);
            repeat (10) pulse();
            n_chk++;
            if (do4[0] !== ~exp_spd[k][1])
                $display("FAIL speed%0d_hi got=%b want=%b", k, do4[0], ~exp_spd[k][1]);
            else n_pass++;
            pulse();
            n_chk++;
            if (do4[0] !== ~exp_spd[k][0])
                $display("FAIL speed%0d_lo got=%b want=%b", k, do4[0], ~exp_spd[k][0]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic exp [16] = '{0,1,1,0,1,1,1,1,1,1,1,1,1,1,1,1};
        logic [31:0] f3, f4;
        mode = 2'd0;
        joy = '0;
        joy[11:0] = 12'h820;
        mouse = '0;
        do_latch();
        pulse(); pulse();
        pclk = 1'b1; step(2);
        rst_n = 1'b0; step(2);
        n_chk++;
        if (do4 !== 2'b11) $display("FAIL midreset_do got=%b want=11", do4);
        else n_pass++;
        rst_n = 1'b1; step(3);
        n_chk++;
        if (do4 !== 2'b11) $display("FAIL midreset_release got=%b want=11", do4);
        else n_pass++;
        pclk = 1'b0; step(2);
        do_latch();
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (do4 !== {1'b1, exp[i]})
                $display("FAIL restart_bit%0d got=%b want=%b", i, do4, {1'b1, exp[i]});
            else n_pass++;
            pulse();
        end
        // Strobe coincident with latch fall
        mode = 2'd1;
        f3 = {8'h00, 2'b00, 2'b00, 4'b0001, 1'b1, 7'd0, 1'b0, 7'd3};
        f4 = {8'h00, 2'b00, 2'b00, 4'b0001, 1'b1, 7'd0, 1'b0, 7'd5};
        strobe(8'd3);
        latch = 1'b1; step(2);
        latch = 1'b0;
        mouse[15:8] = 8'd5;
        mouse[24] = ~mouse[24];
        step(2);
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (do4[0] !== ~f3[31-i])
                $display("FAIL coinc_f3_bit%0d got=%b want=%b", i, do4[0], ~f3[31-i]);
            else n_pass++;
            pulse();
        end
        do_latch();
        for (int i = 0; i < 32; i++) begin
            n_chk++;
            if (do4[0] !== ~f4[31-i])
                $display("FAIL coinc_f4_bit%0d got=%b want=%b", i, do4[0], ~f4[31-i]);
            else n_pass++;
            pulse();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multitap();
        test_mouse();
        test_speed();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
